// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants for the MIPS pipeline register file slice.
//               Default bus widths, the hardwired-zero register index and
//               symbolic names of the architectural registers that the
//               pipeline refers to directly.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Default register file geometry
    localparam int c_DATA_WIDTH = 32;
    localparam int c_ADDR_WIDTH = 5;

    // Architectural register indices
    localparam int c_REG_ZERO = 0;   // $zero
    localparam int c_REG_SP   = 29;  // $sp
    localparam int c_REG_RA   = 31;  // $ra

endpackage : mips_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Pending long-latency write tracker, one busy bit per
//               register. A reserve sets the bit; a port-1 write clears it.
//               A reserve and a clear of the same register in the same cycle
//               leave the bit set, since the reserve is the newer pending
//               write.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               rsv_en/addr    - reserve a destination register
//               we1/waddr1     - long-latency write port (clears busy)
//               ra, rb         - decode read addresses
//               busy_a/busy_b  - pending-write status of ra / rb
//               rsv_busy       - rsv_addr already reserved (WAW hazard)
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rsv_en,
    input  logic [ADDR_WIDTH-1:0] rsv_addr,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] waddr1,
    input  logic [ADDR_WIDTH-1:0] ra,
    input  logic [ADDR_WIDTH-1:0] rb,
    output logic                  busy_a,
    output logic                  busy_b,
    output logic                  rsv_busy
);

    localparam int                    c_NUM_REGS  = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_ZERO_ADDR = ADDR_WIDTH'(c_REG_ZERO);

    logic [c_NUM_REGS-1:0] r_busy;
    logic [c_NUM_REGS-1:0] w_busy_nxt;

    // Per-register next state: set has priority over clear.
    for (genvar i = 0; i < c_NUM_REGS; i++) begin : g_busy
        localparam logic [ADDR_WIDTH-1:0] c_IDX = ADDR_WIDTH'(i);
        logic w_set;
        logic w_clr;

        // Register 0 can never become busy when it is hardwired to zero.
        assign w_set = rsv_en && (rsv_addr == c_IDX) && !(ZERO_REG && (c_IDX == c_ZERO_ADDR));
        assign w_clr = we1 && (waddr1 == c_IDX);
        assign w_busy_nxt[i] = w_set | (r_busy[i] & ~w_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    logic w_zero_a;
    logic w_zero_b;
    logic w_fwd_a;
    logic w_fwd_b;

    assign w_zero_a = ZERO_REG && (ra == c_ZERO_ADDR);
    assign w_zero_b = ZERO_REG && (rb == c_ZERO_ADDR);

    // When the pending result is arriving on port 1 this cycle, the read
    // port already sees it through the bypass, so decode need not stall.
    assign w_fwd_a = BYPASS && we1 && (waddr1 == ra);
    assign w_fwd_b = BYPASS && we1 && (waddr1 == rb);

    assign busy_a   = !rst && r_busy[ra] && !w_zero_a && !w_fwd_a;
    assign busy_b   = !rst && r_busy[rb] && !w_zero_b && !w_fwd_b;

    // Pre-edge view of the bit, unmasked: a second reserve of an
    // outstanding destination is a WAW hazard regardless of forwarding.
    assign rsv_busy = !rst && r_busy[rsv_addr];

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_2w2r_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_2w2r_sb
// Description : MIPS register file with two write ports, two combinational
//               read ports, optional same-cycle write-to-read bypass and an
//               integrated scoreboard of pending long-latency writes.
//               Port 1 (long-latency results) wins over port 0 on both a
//               write collision and a bypass match.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               we0/waddr0/wdata0      - write port 0 (ALU / writeback)
//               we1/waddr1/wdata1      - write port 1 (loads, mul/div)
//               ra, rb / busA, busB    - read addresses / read data
//               rsv_en, rsv_addr       - reserve a pending destination
//               busy_a, busy_b         - ra / rb have a pending write
//               rsv_busy               - rsv_addr already reserved
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_2w2r_sb
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter bit ZERO_REG   = 1'b1,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] waddr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] waddr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic [ADDR_WIDTH-1:0] ra,
    input  logic [ADDR_WIDTH-1:0] rb,
    output logic [DATA_WIDTH-1:0] busA,
    output logic [DATA_WIDTH-1:0] busB,
    input  logic                  rsv_en,
    input  logic [ADDR_WIDTH-1:0] rsv_addr,
    output logic                  busy_a,
    output logic                  busy_b,
    output logic                  rsv_busy
);

    localparam int                    c_NUM_REGS  = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_ZERO_ADDR = ADDR_WIDTH'(c_REG_ZERO);

    logic [DATA_WIDTH-1:0] r_regs [c_NUM_REGS];

    // ------------------------------------------------------------------
    // Write qualification
    // ------------------------------------------------------------------
    logic w_wr1;
    logic w_wr0;

    // A write to the hardwired zero register is dropped outright.
    assign w_wr1 = we1 && !(ZERO_REG && (waddr1 == c_ZERO_ADDR));

    // Port 0 yields to port 1 on an address collision, so only one port
    // ever writes a given register in a cycle.
    assign w_wr0 = we0 && !(ZERO_REG && (waddr0 == c_ZERO_ADDR))
                       && !(w_wr1 && (waddr1 == waddr0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_wr0) begin
                r_regs[waddr0] <= wdata0;
            end
            if (w_wr1) begin
                r_regs[waddr1] <= wdata1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports with optional bypass
    // ------------------------------------------------------------------
    // Later assignments override earlier ones: stored value, then port-0
    // forward, then port-1 forward, then the zero/reset overrides.
    function automatic logic [DATA_WIDTH-1:0] f_read(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] v_data;
        v_data = r_regs[addr];
        if (BYPASS && w_wr0 && (waddr0 == addr)) begin
            v_data = wdata0;
        end
        if (BYPASS && w_wr1 && (waddr1 == addr)) begin
            v_data = wdata1;
        end
        if (ZERO_REG && (addr == c_ZERO_ADDR)) begin
            v_data = '0;
        end
        if (rst) begin
            v_data = '0;
        end
        return v_data;
    endfunction

    always_comb begin
        busA = f_read(ra);
        busB = f_read(rb);
    end

    // ------------------------------------------------------------------
    // Scoreboard of pending long-latency writes
    // ------------------------------------------------------------------
    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG),
        .BYPASS     (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .we1      (we1),
        .waddr1   (waddr1),
        .ra       (ra),
        .rb       (rb),
        .busy_a   (busy_a),
        .busy_b   (busy_b),
        .rsv_busy (rsv_busy)
    );

endmodule : regfile_2w2r_sb
`default_nettype wire

// File: tb/tb_regfile_2w2r_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_2w2r_sb
// Description : Scoreboard testbench for regfile_2w2r_sb. A bypassing
//               instance and a non-bypassing instance share all inputs.
//               The stimulus process drives one vector per cycle and queues
//               its hand-computed expectations; a monitor pops and compares
//               them between clock edges.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_2w2r_sb;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        we0, we1, rsv_en;
    logic [4:0]  waddr0, waddr1, ra, rb, rsv_addr;
    logic [31:0] wdata0, wdata1;
    logic [31:0] busA, busB, busA_nb, busB_nb;
    logic        busy_a, busy_b, rsv_busy;
    logic        busy_a_nb, busy_b_nb, rsv_busy_nb;

    always #5 clk = ~clk;

    regfile_2w2r_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .ra(ra), .rb(rb), .busA(busA), .busB(busB),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_a(busy_a), .busy_b(busy_b), .rsv_busy(rsv_busy)
    );

    regfile_2w2r_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_nb (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .ra(ra), .rb(rb), .busA(busA_nb), .busB(busB_nb),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_a(busy_a_nb), .busy_b(busy_b_nb), .rsv_busy(rsv_busy_nb)
    );

    // Field-select bits for an expectation
    localparam logic [6:0] M_A   = 7'b000_0001;
    localparam logic [6:0] M_B   = 7'b000_0010;
    localparam logic [6:0] M_BA  = 7'b000_0100;
    localparam logic [6:0] M_BB  = 7'b000_1000;
    localparam logic [6:0] M_RS  = 7'b001_0000;
    localparam logic [6:0] M_ANB = 7'b010_0000;
    localparam logic [6:0] M_BAN = 7'b100_0000;

    typedef struct {
        string       name;
        logic [6:0]  mask;
        logic [31:0] a, b, a_nb;
        logic        ba, bb, rs, ba_nb;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s.%s: got %h expected %h", nm, fld, act, req);
    endtask

    // Monitor: combinational outputs settle 2 time units after the vector
    // is applied at the falling edge, well before the next rising edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.mask[0]) cmp(e.name, "busA",      busA,             e.a);
                if (e.mask[1]) cmp(e.name, "busB",      busB,             e.b);
                if (e.mask[2]) cmp(e.name, "busy_a",    {31'd0, busy_a},    {31'd0, e.ba});
                if (e.mask[3]) cmp(e.name, "busy_b",    {31'd0, busy_b},    {31'd0, e.bb});
                if (e.mask[4]) cmp(e.name, "rsv_busy",  {31'd0, rsv_busy},  {31'd0, e.rs});
                if (e.mask[5]) cmp(e.name, "busA_nb",   busA_nb,          e.a_nb);
                if (e.mask[6]) cmp(e.name, "busy_a_nb", {31'd0, busy_a_nb}, {31'd0, e.ba_nb});
            end
        end
    end

    task automatic idle();
        rst = 1'b0; we0 = 1'b0; we1 = 1'b0; rsv_en = 1'b0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        ra = '0; rb = '0; rsv_addr = '0;
    endtask

    // Queue the expectation for the vector currently applied, then advance.
    task automatic step(input string nm, input logic [6:0] m,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] a_nb,
                        input logic ba, input logic bb, input logic rs, input logic ba_nb);
        exp_t e;
        e.name = nm; e.mask = m; e.a = a; e.b = b; e.a_nb = a_nb;
        e.ba = ba; e.bb = bb; e.rs = rs; e.ba_nb = ba_nb;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin : stimulus
        idle();
        @(negedge clk);

        // Reset state
        idle(); rst = 1'b1;
        step("rst_init", M_A|M_B|M_BA|M_BB|M_RS|M_ANB, 0, 0, 0, 0, 0, 0, 0);

        // Reset clears preloaded data and overrides a same-cycle write
        idle(); we0 = 1; waddr0 = 5; wdata0 = 32'h1234; ra = 5;
        step("preload_r5", M_A|M_ANB, 32'h1234, 0, 0, 0, 0, 0, 0);
        idle(); rst = 1; we0 = 1; waddr0 = 6; wdata0 = 32'h77; ra = 5; rb = 6;
        step("rst_forced", M_A|M_B|M_ANB, 0, 0, 0, 0, 0, 0, 0);
        idle(); ra = 5; rb = 6;
        step("after_rst", M_A|M_B|M_BA|M_BB|M_RS|M_ANB, 0, 0, 0, 0, 0, 0, 0);

        // Zero register: never written, never bypassed, never busy
        idle(); we0 = 1; waddr0 = 0; wdata0 = 32'hDEADBEEF; ra = 0;
        step("zero_wr", M_A|M_ANB, 0, 0, 0, 0, 0, 0, 0);
        idle(); ra = 0; rsv_en = 1; rsv_addr = 0;
        step("zero_rsv", M_A|M_BA|M_RS, 0, 0, 0, 0, 0, 0, 0);
        idle(); ra = 0; rsv_addr = 0;
        step("zero_after", M_A|M_BA|M_RS|M_BAN, 0, 0, 0, 0, 0, 0, 0);

        // Port-0 bypass
        idle(); we0 = 1; waddr0 = 7; wdata0 = 32'h11; ra = 7;
        step("r7_pre", M_A|M_ANB, 32'h11, 0, 0, 0, 0, 0, 0);
        idle(); we0 = 1; waddr0 = 7; wdata0 = 32'h22; ra = 7;
        step("r7_bypass", M_A|M_ANB, 32'h22, 0, 32'h11, 0, 0, 0, 0);
        idle(); ra = 7;
        step("r7_after", M_A|M_ANB, 32'h22, 0, 32'h22, 0, 0, 0, 0);

        // Write collision: port 1 wins
        idle(); we0 = 1; waddr0 = 9; wdata0 = 32'hAAAA; we1 = 1; waddr1 = 9; wdata1 = 32'hBBBB; ra = 9; rb = 9;
        step("collide", M_A|M_B|M_ANB|M_BB, 32'hBBBB, 32'hBBBB, 0, 0, 0, 0, 0);
        idle(); ra = 9; rb = 9;
        step("collide_after", M_A|M_B|M_ANB, 32'hBBBB, 32'hBBBB, 32'hBBBB, 0, 0, 0, 0);

        // Scoreboard set / WAW / clear with bypass mask
        idle(); rsv_en = 1; rsv_addr = 12; ra = 12;
        step("rsv12", M_BA|M_RS, 0, 0, 0, 0, 0, 0, 0);
        idle(); rsv_en = 1; rsv_addr = 12; ra = 12;
        step("rsv12_waw", M_BA|M_RS|M_BAN, 0, 0, 0, 1, 0, 1, 1);
        idle(); we1 = 1; waddr1 = 12; wdata1 = 32'hC0DE; ra = 12; rsv_addr = 12;
        step("wr1_r12", M_A|M_ANB|M_BA|M_RS|M_BAN, 32'hC0DE, 0, 0, 0, 0, 1, 1);
        idle(); ra = 12; rsv_addr = 12;
        step("r12_clear", M_A|M_ANB|M_BA|M_RS|M_BAN, 32'hC0DE, 0, 32'hC0DE, 0, 0, 0, 0);
        idle(); rsv_en = 1; rsv_addr = 12; ra = 12;
        step("rsv12_again", M_BA, 0, 0, 0, 0, 0, 0, 0);
        idle(); we0 = 1; waddr0 = 12; wdata0 = 32'h1111; ra = 12; rb = 12;
        step("wr0_r12", M_A|M_ANB|M_BA|M_BB, 32'h1111, 0, 32'hC0DE, 1, 1, 0, 0);
        idle(); ra = 12;
        step("r12_still", M_A|M_ANB|M_BA, 32'h1111, 0, 32'h1111, 1, 0, 0, 0);

        // Reserve / clear race: reserve wins
        idle(); rsv_en = 1; rsv_addr = 3; ra = 3;
        step("rsv3", M_A|M_BA, 0, 0, 0, 0, 0, 0, 0);
        idle(); rsv_en = 1; rsv_addr = 3; we1 = 1; waddr1 = 3; wdata1 = 32'h55; ra = 3;
        step("race3", M_A|M_ANB|M_BA|M_BAN, 32'h55, 0, 0, 0, 0, 0, 1);
        idle(); ra = 3; rsv_addr = 3;
        step("race3_after", M_A|M_BA|M_RS|M_BAN, 32'h55, 0, 0, 1, 0, 1, 1);

        // Mid-operation reset discards reservations and data
        idle(); rst = 1; rsv_en = 1; rsv_addr = 4; ra = 3; rb = 4;
        step("rst_mid", M_A|M_B|M_BA|M_BB|M_RS|M_BAN, 0, 0, 0, 0, 0, 0, 0);
        idle(); ra = 3; rb = 4; rsv_addr = 12;
        step("rst_mid_after", M_A|M_B|M_BA|M_BB|M_RS|M_BAN, 0, 0, 0, 0, 0, 0, 0);

        // Port-1 write to zero register is dropped
        idle(); we1 = 1; waddr1 = 0; wdata1 = 32'hFFFF; ra = 0;
        step("zero_wr1", M_A|M_ANB, 0, 0, 0, 0, 0, 0, 0);

        // Both ports to different registers ($ra, $sp)
        idle(); we1 = 1; waddr1 = 5'(c_REG_RA); wdata1 = 32'hCAFE;
        we0 = 1; waddr0 = 5'(c_REG_SP); wdata0 = 32'hBEEF; ra = 5'(c_REG_RA); rb = 5'(c_REG_SP);
        step("ra_sp_wr", M_A|M_B|M_ANB, 32'hCAFE, 32'hBEEF, 0, 0, 0, 0, 0);
        idle(); ra = 5'(c_REG_RA); rb = 5'(c_REG_SP);
        step("ra_sp_after", M_A|M_B|M_ANB, 32'hCAFE, 32'hBEEF, 32'hCAFE, 0, 0, 0, 0);

        idle();
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_total += exp_q.size();
            $display("FAIL drain: got %0d unchecked expectations expected 0", exp_q.size());
        end
        #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_regfile_2w2r_sb
`default_nettype wire

// File: doc/regfile_2w2r_sb.md
Name: regfile_2w2r_sb

Overview:
- Next-generation MIPS register file: parametrised data width and register count.
- Two write ports: port 0 for ALU/writeback, port 1 for long-latency results such as loads and multiply/divide.
- Two combinational read ports with optional write-to-read bypass.
- Integrated scoreboard of pending long-latency writes, used by decode for stall generation.

Parameters:
- DATA_WIDTH, 32, width of each register and of every data bus
- ADDR_WIDTH, 5, register address width; NUM_REGS = 2**ADDR_WIDTH
- ZERO_REG, 1, 1 = register 0 is hardwired to zero; 0 = register 0 is an ordinary register
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return the stored value only

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- we0  in  1  write enable, port 0
- waddr0  in  ADDR_WIDTH  write address, port 0
- wdata0  in  DATA_WIDTH  write data, port 0
- we1  in  1  write enable, port 1 (long-latency port)
- waddr1  in  ADDR_WIDTH  write address, port 1
- wdata1  in  DATA_WIDTH  write data, port 1
- ra  in  ADDR_WIDTH  read address A
- rb  in  ADDR_WIDTH  read address B
- busA  out  DATA_WIDTH  read data A (combinational)
- busB  out  DATA_WIDTH  read data B (combinational)
- rsv_en  in  1  reserve a destination for a pending long-latency write
- rsv_addr  in  ADDR_WIDTH  register to reserve
- busy_a  out  1  register ra has a pending long-latency write
- busy_b  out  1  register rb has a pending long-latency write
- rsv_busy  out  1  rsv_addr is already reserved (WAW hazard indication)

Behaviour:
- Reset: rst sampled high at a clock edge clears all NUM_REGS registers and all scoreboard bits to 0 at that edge.
  - While rst is high, busA, busB, busy_a, busy_b and rsv_busy are forced to 0.
  - rst high overrides every write and reserve in the same cycle. Reset mid-operation discards all pending reservations.
- Writes: on the rising edge, if weN=1 then registers[waddrN] <= wdataN.
  - With ZERO_REG=1, a write to address 0 is discarded and register 0 always reads 0.
- Write collision: we0 and we1 both high to the same address -> port 1 data is stored and port 0 data is dropped. No error flag.
- Reads: busX = registers[rX] combinationally, zero latency.
- Bypass (BYPASS=1): if rX equals an active waddrN whose write is not discarded, busX returns wdataN in the same cycle.
  - Port 1 has priority over port 0 when both match.
  - Address 0 with ZERO_REG=1 always returns 0 and is never bypassed.
- Scoreboard: one busy bit per register.
  - rsv_en=1 sets busy[rsv_addr] at the edge. A reserve of address 0 is ignored when ZERO_REG=1.
  - A port-1 write (we1=1) clears busy[waddr1] at the edge.
  - Port-0 writes never touch the scoreboard.
  - Reserve and port-1 clear to the same address in the same cycle -> the bit stays set, because the reserve is the newer pending write.
  - Reserve of an already-busy register keeps it set (no counting). rsv_busy = busy[rsv_addr] pre-edge, so decode stalls on the WAW hazard.
- busy_x = busy[rX], also 0 for address 0 when ZERO_REG=1.
  - With BYPASS=1, busy_x is masked to 0 when we1=1 and waddr1==rX in the same cycle, since the data is being forwarded.
  - With BYPASS=0, no such masking is applied.
- All reads are free of X: registers are always initialised by reset. No simulation-only constructs in the synthesised path.

Decomposition:
- Shared package `mips_pkg` holds:
  - the default DATA_WIDTH and ADDR_WIDTH constants
  - the REG_ZERO address constant
  - symbolic names for the MIPS registers used by the pipeline ($ra=31, $sp=29)
- One sub-module, `regfile_scoreboard`:
  - holds the busy bit vector and the set/clear priority logic
  - produces busy_a, busy_b and rsv_busy
  - takes clk and rst with the same synchronous, active-high reset
- The top level holds the storage array, collision resolution and bypass muxes.

Test Plan:
- Reset: preload r5=0x1234 (rst=0), then raise rst for one cycle with we0=1 to r6 -> afterwards r5 and r6 both read 0, all busy bits 0; during rst, busA=busB=0.
- Zero register: we0=1, waddr0=0, wdata0=0xDEADBEEF; ra=0 -> busA=0 in the same cycle and after the edge; rsv_en to r0 -> busy never set.
- Bypass: r7 holds 0x11; we0=1 to r7 with wdata0=0x22 and ra=7 -> busA=0x22 in that cycle (0x11 with BYPASS=0) and 0x22 after the edge.
- Collision: we0 (0xAAAA) and we1 (0xBBBB) both to r9 -> busB with rb=9 returns 0xBBBB pre-edge (bypass) and post-edge.
- Scoreboard: rsv_en r12 -> busy_a=1 (ra=12) next cycle; second rsv_en r12 -> rsv_busy=1; we1 to r12 -> busy_a=0 in that cycle (bypass mask) and after; we0 to r12 while reserved -> busy stays 1.
- Reserve/clear race: r3 busy; same cycle rsv_en r3 and we1 r3 with 0x55 -> r3=0x55 and busy[r3] remains 1.
